// File: rtl/mux_pkg.sv
// Shared helpers for the binary-select mux tree: level count and stage offsets.
package mux_pkg;

   // Ceiling of a/b; used to count how many SPLIT-way levels cover the select bits.
   function automatic int unsigned clog2_ceil_div(input int unsigned a, input int unsigned b);
      if (b == 0) return 0;
      return (a + b - 1) / b;
   endfunction

   // Start index of level l's input vector inside the flattened stage array.
   // Level k holds 2**(leaves_log - k*split_log) entries.
   function automatic int unsigned lvl_offset(input int unsigned leaves_log,
                                              input int unsigned split_log,
                                              input int unsigned l);
      int unsigned off;
      off = 0;
      for (int unsigned k = 0; k < l; k++) begin
         off = off + (32'(1) << (leaves_log - k * split_log));
      end
      return off;
   endfunction

endpackage

// File: rtl/mux_bin_node.sv
// Combinational SPLIT-way multiplexer node of the select tree.
module mux_bin_node #(
   parameter type         DAT_T     = logic [8-1:0],
   parameter int unsigned SPLIT     = 4,
   localparam int unsigned SPLIT_LOG = $clog2(SPLIT)
) (
   input  logic [SPLIT_LOG-1:0] sel,
   input  DAT_T                 ary [SPLIT-1:0],
   output DAT_T                 dat_c
);

   // SPLIT is a power of two, so every select value addresses a real input.
   assign dat_c = ary[sel];

endmodule

// File: rtl/mux_bin_tree.sv
// WIDTH-input binary-select multiplexer with a registered output.
module mux_bin_tree
   import mux_pkg::*;
#(
   parameter type         DAT_T          = logic [8-1:0],
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned SPLIT          = 4,
   parameter int unsigned IMPLEMENTATION = 0,
   localparam int unsigned WIDTH_LOG     = $clog2(WIDTH),
   localparam int unsigned BIN_W         = (WIDTH_LOG == 0) ? 1 : WIDTH_LOG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] bin,
   input  DAT_T             ary [WIDTH-1:0],
   output DAT_T             dat
);

   localparam int unsigned SPLIT_LOG = $clog2(SPLIT);
   localparam int unsigned LEVELS    = clog2_ceil_div(WIDTH_LOG, SPLIT_LOG);
   localparam int unsigned TREE_LOG  = LEVELS * SPLIT_LOG;
   localparam int unsigned LEAVES    = 32'(1) << TREE_LOG;
   localparam int unsigned STG_N     = lvl_offset(TREE_LOG, SPLIT_LOG, LEVELS) + 1;

   DAT_T sel;

   if (WIDTH == 1) begin : g_single
      // A single input needs no select; bin carries no information here.
      logic unused_bin;
      assign unused_bin = ^bin;
      assign sel        = ary[0];
   end else if (IMPLEMENTATION == 0) begin : g_tree
      // Flattened storage: leaves first, then each level's node outputs, root last.
      DAT_T                stg [STG_N];
      logic [TREE_LOG-1:0] bin_x;

      // Select bits above WIDTH_LOG are zero, so a ragged top level acts as a reduced fan-in node.
      assign bin_x = TREE_LOG'(bin);

      // Leaves beyond WIDTH read as zero, which also makes bin >= WIDTH select zero.
      for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
         if (i < WIDTH) begin : g_real
            assign stg[i] = ary[i];
         end else begin : g_pad
            assign stg[i] = '0;
         end
      end

      for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
         localparam int unsigned IN_OFF  = lvl_offset(TREE_LOG, SPLIT_LOG, l);
         localparam int unsigned OUT_OFF = lvl_offset(TREE_LOG, SPLIT_LOG, l + 1);
         localparam int unsigned NODES   = 32'(1) << (TREE_LOG - (l + 1) * SPLIT_LOG);

         for (genvar n = 0; n < NODES; n++) begin : g_node
            DAT_T grp [SPLIT-1:0];

            for (genvar k = 0; k < SPLIT; k++) begin : g_in
               assign grp[k] = stg[IN_OFF + n * SPLIT + k];
            end

            mux_bin_node #(
               .DAT_T (DAT_T),
               .SPLIT (SPLIT)
            ) u_node (
               .sel   (bin_x[l * SPLIT_LOG +: SPLIT_LOG]),
               .ary   (grp),
               .dat_c (stg[OUT_OFF + n])
            );
         end
      end

      assign sel = stg[STG_N - 1];
   end else begin : g_flat
      if ((32'(1) << WIDTH_LOG) == WIDTH) begin : g_pow2
         assign sel = ary[bin];
      end else begin : g_ragged
         assign sel = (bin < BIN_W'(WIDTH)) ? ary[bin] : '0;
      end
   end

   // Output register; reset wins over the load.
   always_ff @(posedge clk) begin
      if (rst) begin
         dat <= '0;
      end else begin
         dat <= sel;
      end
   end

endmodule

// File: tb/tb_mux_bin_tree.sv
// Self-checking bench for mux_bin_tree: directed vector table plus randomized model comparison.
module tb_mux_bin_tree;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Main instance: WIDTH=16, SPLIT=4, tree.
   logic [3:0] mbin;
   logic [7:0] mary [15:0];
   logic [7:0] mdat;

   // Ragged instances: WIDTH=10, SPLIT=4, tree and flat.
   logic [3:0] rbin;
   logic [7:0] rary [9:0];
   logic [7:0] rdat0, rdat1;

   // WIDTH=16, SPLIT=2, tree and flat.
   logic [3:0] ebin;
   logic [7:0] eary [15:0];
   logic [7:0] edat0, edat1;

   // WIDTH=32, SPLIT=8, tree (reduced top node) and flat.
   logic [4:0] fbin;
   logic [7:0] fary [31:0];
   logic [7:0] fdat0, fdat1;

   int checks = 0;
   int errors = 0;

   mux_bin_tree #(.DAT_T(logic [7:0]), .WIDTH(16), .SPLIT(4), .IMPLEMENTATION(0)) dut_m (
      .clk(clk), .rst(rst), .bin(mbin), .ary(mary), .dat(mdat));
   mux_bin_tree #(.DAT_T(logic [7:0]), .WIDTH(10), .SPLIT(4), .IMPLEMENTATION(0)) dut_r0 (
      .clk(clk), .rst(rst), .bin(rbin), .ary(rary), .dat(rdat0));
   mux_bin_tree #(.DAT_T(logic [7:0]), .WIDTH(10), .SPLIT(4), .IMPLEMENTATION(1)) dut_r1 (
      .clk(clk), .rst(rst), .bin(rbin), .ary(rary), .dat(rdat1));
   mux_bin_tree #(.DAT_T(logic [7:0]), .WIDTH(16), .SPLIT(2), .IMPLEMENTATION(0)) dut_e0 (
      .clk(clk), .rst(rst), .bin(ebin), .ary(eary), .dat(edat0));
   mux_bin_tree #(.DAT_T(logic [7:0]), .WIDTH(16), .SPLIT(2), .IMPLEMENTATION(1)) dut_e1 (
      .clk(clk), .rst(rst), .bin(ebin), .ary(eary), .dat(edat1));
   mux_bin_tree #(.DAT_T(logic [7:0]), .WIDTH(32), .SPLIT(8), .IMPLEMENTATION(0)) dut_f0 (
      .clk(clk), .rst(rst), .bin(fbin), .ary(fary), .dat(fdat0));
   mux_bin_tree #(.DAT_T(logic [7:0]), .WIDTH(32), .SPLIT(8), .IMPLEMENTATION(1)) dut_f1 (
      .clk(clk), .rst(rst), .bin(fbin), .ary(fary), .dat(fdat1));

   typedef struct {
      logic       rst;
      logic [3:0] bin;
      logic [7:0] a9;
      logic [7:0] a3;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] b, input logic [7:0] a9,
                               input logic [7:0] a3, input logic [7:0] e);
      vec_t v;
      v.rst = r; v.bin = b; v.a9 = a9; v.a3 = a3; v.exp = e;
      return v;
   endfunction

   initial begin
      logic [7:0] m_exp, r_exp, e_exp, f_exp;

      rst  = 1'b1;
      mbin = '0; rbin = '0; ebin = '0; fbin = '0;
      for (int i = 0; i < 16; i++) begin mary[i] = 8'(i); eary[i] = '0; end
      for (int i = 0; i < 10; i++) rary[i] = '0;
      for (int i = 0; i < 32; i++) fary[i] = '0;

      // Reset holds dat at zero, then the held select appears one edge after release.
      vecs.push_back(mk(1'b1, 4'd5, 8'h09, 8'h03, 8'h00));
      vecs.push_back(mk(1'b1, 4'd5, 8'h09, 8'h03, 8'h00));
      vecs.push_back(mk(1'b0, 4'd5, 8'h09, 8'h03, 8'h05));
      // Full sweep with ary[i] = i.
      for (int b = 0; b < 16; b++) vecs.push_back(mk(1'b0, 4'(b), 8'h09, 8'h03, 8'(b)));
      // Data change under a held select; a non-selected change is invisible.
      vecs.push_back(mk(1'b0, 4'd9, 8'h09, 8'h03, 8'h09));
      vecs.push_back(mk(1'b0, 4'd9, 8'hA5, 8'h03, 8'hA5));
      vecs.push_back(mk(1'b0, 4'd9, 8'hA5, 8'h5A, 8'hA5));
      vecs.push_back(mk(1'b0, 4'd3, 8'hA5, 8'h5A, 8'h5A));
      // Mid-run reset during a sweep.
      vecs.push_back(mk(1'b0, 4'd6, 8'h09, 8'h03, 8'h06));
      vecs.push_back(mk(1'b1, 4'd7, 8'h09, 8'h03, 8'h00));
      vecs.push_back(mk(1'b0, 4'd8, 8'h09, 8'h03, 8'h08));
      vecs.push_back(mk(1'b0, 4'd9, 8'h09, 8'h03, 8'h09));

      for (int i = 0; i < vecs.size(); i++) begin
         rst     = vecs[i].rst;
         mbin    = vecs[i].bin;
         mary[9] = vecs[i].a9;
         mary[3] = vecs[i].a3;
         tick();
         check($sformatf("vec%0d_bin%0d_rst%0d", i, vecs[i].bin, vecs[i].rst), mdat, vecs[i].exp);
      end

      // Ragged WIDTH=10: ary[i] = i+1, out-of-range selects read zero.
      rst = 1'b0;
      for (int i = 0; i < 10; i++) rary[i] = 8'(i + 1);
      for (int b = 0; b < 16; b++) begin
         rbin  = 4'(b);
         r_exp = (b < 10) ? 8'(b + 1) : 8'h00;
         tick();
         check($sformatf("ragged_tree_bin%0d", b), rdat0, r_exp);
         check($sformatf("ragged_flat_bin%0d", b), rdat1, r_exp);
      end

      // Random select/data with occasional reset, against the index-with-bounds model.
      for (int c = 0; c < 1000; c++) begin
         rst  = ($urandom_range(0, 31) == 0);
         mbin = 4'($urandom);
         rbin = 4'($urandom);
         ebin = 4'($urandom);
         fbin = 5'($urandom);
         for (int i = 0; i < 16; i++) begin mary[i] = 8'($urandom); eary[i] = 8'($urandom); end
         for (int i = 0; i < 10; i++) rary[i] = 8'($urandom);
         for (int i = 0; i < 32; i++) fary[i] = 8'($urandom);

         m_exp = rst ? 8'h00 : mary[int'(mbin)];
         r_exp = (rst || int'(rbin) >= 10) ? 8'h00 : rary[int'(rbin)];
         e_exp = rst ? 8'h00 : eary[int'(ebin)];
         f_exp = rst ? 8'h00 : fary[int'(fbin)];
         tick();
         check($sformatf("rand%0d_w16s4", c),      mdat,  m_exp);
         check($sformatf("rand%0d_w10s4_tree", c), rdat0, r_exp);
         check($sformatf("rand%0d_w10s4_flat", c), rdat1, r_exp);
         check($sformatf("rand%0d_w16s2_tree", c), edat0, e_exp);
         check($sformatf("rand%0d_w16s2_flat", c), edat1, e_exp);
         check($sformatf("rand%0d_w32s8_tree", c), fdat0, f_exp);
         check($sformatf("rand%0d_w32s8_flat", c), fdat1, f_exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
